// File: rtl/approx_mul_rr_sched_if.sv
// Request/result bundle for approx_mul_rr_sched: NREQ operand lanes in, one tagged product out.
// master = requester/consumer side, slave = the scheduler.
interface approx_mul_rr_sched_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_x;
  logic [8*NREQ-1:0] req_y;
  logic [NREQ-1:0]   req_ready;
  logic              out_valid;
  logic              out_ready;
  logic [15:0]       out_z;
  logic [IDW-1:0]    out_id;
  logic [CNTW-1:0]   op_count;
  logic              err_clr;
  logic [31:0]       err_sum;
  logic [15:0]       err_max;

  modport master (
    output req_valid, req_x, req_y, out_ready, err_clr,
    input  req_ready, out_valid, out_z, out_id, op_count, err_sum, err_max
  );

  modport slave (
    input  req_valid, req_x, req_y, out_ready, err_clr,
    output req_ready, out_valid, out_z, out_id, op_count, err_sum, err_max
  );
endinterface

// File: rtl/approx_mul_rr_sched.sv
// Round-robin scheduler sharing one Mitchell-style approximate 8x8 multiplier among NREQ lanes.
// Optional macro APPROX_ERR_MON_EN adds an exact reference multiplier and |error| sum/max monitor.
module approx_mul_rr_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int CNTW = 16
) (
  input logic                   clk,
  input logic                   rst,
  approx_mul_rr_sched_if.slave  bus
);
  logic [IDW-1:0]  rr_ptr_reg;
  logic            out_valid_reg;
  logic [15:0]     out_z_reg;
  logic [IDW-1:0]  out_id_reg;
  logic [CNTW-1:0] op_count_reg;

  logic [7:0]      x_arr [NREQ];
  logic [7:0]      y_arr [NREQ];
  logic [IDW:0]    cand_sum [NREQ];
  logic [IDW-1:0]  cand_idx [NREQ];

  logic            grant_found;
  logic [IDW-1:0]  grant_idx;
  logic [IDW-1:0]  rr_ptr_next;
  logic            can_issue;
  logic            transfer;

  logic [7:0]      x_sel, y_sel, nx, ny;
  logic [2:0]      kx, ky;
  logic [3:0]      fsum;
  logic [3:0]      exp_sum;
  logic [18:0]     wide;
  logic [15:0]     approx_z;

  function automatic logic [2:0] lod8(input logic [7:0] v);
    lod8 = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) lod8 = 3'(b);
    end
  endfunction

  assign can_issue = !out_valid_reg || bus.out_ready;
  assign transfer  = grant_found && can_issue && !rst;

  // cand_idx[gi] is the gi-th lane in scan order starting at rr_ptr
  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_lane
      assign x_arr[gi]    = bus.req_x[8*gi +: 8];
      assign y_arr[gi]    = bus.req_y[8*gi +: 8];
      assign cand_sum[gi] = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
      assign cand_idx[gi] = (cand_sum[gi] >= (IDW+1)'(NREQ)) ?
                            IDW'(cand_sum[gi] - (IDW+1)'(NREQ)) : cand_sum[gi][IDW-1:0];
      assign bus.req_ready[gi] = grant_found && (grant_idx == IDW'(gi)) && can_issue && !rst;
    end
  endgenerate

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (bus.req_valid[cand_idx[k]]) begin
        grant_found = 1'b1;
        grant_idx   = cand_idx[k];
      end
    end
  end

  assign rr_ptr_next = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + IDW'(1);

  // Log-domain product: 3-bit truncated mantissas added, carry bumps the exponent.
  // With a carry the mantissa sum itself is the result mantissa, so it is always {1,fsum[2:0]}.
  always_comb begin
    x_sel    = x_arr[grant_idx];
    y_sel    = y_arr[grant_idx];
    kx       = lod8(x_sel);
    ky       = lod8(y_sel);
    nx       = x_sel << (3'd7 - kx);
    ny       = y_sel << (3'd7 - ky);
    fsum     = {1'b0, nx[6:4]} + {1'b0, ny[6:4]};
    exp_sum  = {1'b0, kx} + {1'b0, ky} + {3'b000, fsum[3]};
    wide     = {15'd0, 1'b1, fsum[2:0]} << exp_sum;
    approx_z = (x_sel == 8'd0 || y_sel == 8'd0) ? 16'd0 : wide[18:3];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_reg    <= '0;
      out_valid_reg <= 1'b0;
      out_z_reg     <= '0;
      out_id_reg    <= '0;
      op_count_reg  <= '0;
    end else if (transfer) begin
      out_z_reg     <= approx_z;
      out_id_reg    <= grant_idx;
      out_valid_reg <= 1'b1;
      rr_ptr_reg    <= rr_ptr_next;
      if (op_count_reg != '1) op_count_reg <= op_count_reg + CNTW'(1);
    end else if (bus.out_ready && out_valid_reg) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_reg;
  assign bus.out_z     = out_z_reg;
  assign bus.out_id    = out_id_reg;
  assign bus.op_count  = op_count_reg;

`ifdef APPROX_ERR_MON_EN
  logic [15:0] exact_z;
  logic [15:0] err_abs;
  logic [32:0] err_acc;
  logic [31:0] err_sum_reg;
  logic [15:0] err_max_reg;

  always_comb begin
    exact_z = 16'(x_sel) * 16'(y_sel);
    err_abs = (exact_z >= approx_z) ? exact_z - approx_z : approx_z - exact_z;
    err_acc = {1'b0, err_sum_reg} + {17'd0, err_abs};
  end

  // Clear wins over an accumulation in the same cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum_reg <= '0;
      err_max_reg <= '0;
    end else if (bus.err_clr) begin
      err_sum_reg <= '0;
      err_max_reg <= '0;
    end else if (transfer) begin
      err_sum_reg <= err_acc[32] ? 32'hFFFF_FFFF : err_acc[31:0];
      if (err_abs > err_max_reg) err_max_reg <= err_abs;
    end
  end

  assign bus.err_sum = err_sum_reg;
  assign bus.err_max = err_max_reg;
`else
  logic unused_err_clr;
  assign unused_err_clr = bus.err_clr;
  assign bus.err_sum    = '0;
  assign bus.err_max    = '0;
`endif

endmodule
